// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Round-robin arbiter in front of the register table. Requesters (index 0 =
//   SPI) raise single read or write accesses. One winner per access. The winner's
//   address and data are latched and presented to the table with a one-cycle
//   strobe. Reads return table data on rd_data with a one-cycle rd_valid strobe.
//
//   Optional feature: define REG_ARB_SPI_PRIO_EN to give requester 0 absolute
//   priority in IDLE. In that mode the RR pointer only advances on grants to
//   requesters 1..NUM_REQ-1.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   req        per-requester level request
//   req_rd     per-requester op select (1 = read, 0 = write)
//   req_addr   flat requester addresses, slice i = requester i
//   req_din    flat requester write data, slice i = requester i
//   ack        one-hot grant acknowledge (ACCESS cycle)
//   rd_valid   one-hot read-data strobe, registered
//   rd_data    read data, valid with rd_valid
//   busy       high while not IDLE
//   rt_addr    table address (registered, holds between accesses)
//   rt_din     table write data (registered, holds between accesses)
//   rt_wr      table write strobe
//   rt_rd      table read strobe
//   rt_dout    table read data, valid one cycle after rt_rd
module reg_access_arbiter #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rt_addr,
    output logic [DATA_W-1:0]         rt_din,
    output logic                      rt_wr,
    output logic                      rt_rd,
    input  logic [DATA_W-1:0]         rt_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     win_q, win_d;
    logic                op_rd_q, op_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    // Arbitration result for the current IDLE cycle
    logic                found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     scan_id;
    // One-hot decode of the latched winner
    logic [NUM_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]     ptr_next;

    always_comb begin
        found   = 1'b0;
        pick_id = '0;
        scan_id = '0;
`ifdef REG_ARB_SPI_PRIO_EN
        if (req[0]) begin
            found   = 1'b1;
            pick_id = '0;
        end
`endif
        // Scan ptr, ptr+1, .., wrapping mod NUM_REQ; first set bit wins.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req[scan_id]) begin
                found   = 1'b1;
                pick_id = scan_id;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (win_q == ID_W'(i));
        end
        ptr_next = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);
    end

    // Next-state and strobe outputs
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        op_rd_d    = op_rd_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        ack        = '0;
        rt_wr      = 1'b0;
        rt_rd      = 1'b0;
        busy       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick_id;
                    op_rd_d = req_rd[pick_id];
                    addr_d  = req_addr[pick_id*ADDR_W +: ADDR_W];
                    din_d   = req_din[pick_id*DATA_W +: DATA_W];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ack   = grant_oh;
                rt_wr = !op_rd_q;
                rt_rd = op_rd_q;
`ifdef REG_ARB_SPI_PRIO_EN
                if (win_q != '0) begin
                    ptr_d = ptr_next;
                end
`else
                ptr_d = ptr_next;
`endif
                state_d = op_rd_q ? S_RDATA : S_IDLE;
            end
            S_RDATA: begin
                // Table data is captured here and presented next cycle, while
                // the FSM is already back in IDLE arbitrating the next access.
                rd_data_d  = rt_dout;
                rd_valid_d = grant_oh;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            op_rd_q    <= op_rd_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rt_addr  = addr_q;
    assign rt_din   = din_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;

    localparam int N  = 6;
    localparam int AW = 7;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      req_rd = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_din = '0;
    logic [N-1:0]      ack;
    logic [N-1:0]      rd_valid;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic [AW-1:0]     rt_addr;
    logic [DW-1:0]     rt_din;
    logic              rt_wr;
    logic              rt_rd;
    logic [DW-1:0]     rt_dout = '0;

    reg_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_addr(req_addr),
        .req_din(req_din), .ack(ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .rt_addr(rt_addr), .rt_din(rt_din), .rt_wr(rt_wr),
        .rt_rd(rt_rd), .rt_dout(rt_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    function automatic logic [DW-1:0] init_val(int a);
        return 16'(a * 257) ^ 16'h5A3C;
    endfunction

    // Register table model: one-cycle read latency, re-initialised by reset
    logic [DW-1:0] tbl [128];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) tbl[i] <= init_val(i);
        end else begin
            if (rt_wr) tbl[rt_addr] <= rt_din;
            if (rt_rd) rt_dout <= tbl[rt_addr];
        end
    end

    // Reference model
    typedef struct {
        int           id;
        logic         rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } acc_t;
    typedef struct {
        int           id;
        logic [DW-1:0] data;
    } rdx_t;

    acc_t exp_acc[$];
    rdx_t exp_rd[$];
    int            mptr;
    logic [DW-1:0] ref_mem [128];
    logic [AW-1:0] sa [N];
    logic [DW-1:0] sd [N];
    logic [N-1:0]  srd;

    task automatic model_reset();
        mptr = 0;
        exp_acc.delete();
        exp_rd.delete();
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    endtask

    function automatic int pick(logic [N-1:0] set, int ptr);
`ifdef REG_ARB_SPI_PRIO_EN
        if (set[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (set[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_grant(int w);
        acc_t a;
        rdx_t r;
        a.id = w; a.rd = srd[w]; a.addr = sa[w]; a.din = sd[w];
        exp_acc.push_back(a);
        if (srd[w]) begin
            r.id = w; r.data = ref_mem[sa[w]];
            exp_rd.push_back(r);
        end else begin
            ref_mem[sa[w]] = sd[w];
        end
`ifdef REG_ARB_SPI_PRIO_EN
        if (w != 0) mptr = (w + 1) % N;
`else
        mptr = (w + 1) % N;
`endif
    endtask

    // Monitor / scoreboard
    int            last_ack_cyc = -1;
    int            last_rdv_cyc = -1;
    logic [DW-1:0] last_rd_data = '0;
    acc_t          me;
    rdx_t          mr;
    logic [N-1:0]  exp_oh;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(ack) > 1 || $countones(rd_valid) > 1 || (rt_wr && rt_rd) ||
                ((rt_wr || rt_rd) != (|ack))) begin
                fails++;
                $display("FAIL strobe_excl: ack=%b rd_valid=%b rt_wr=%b rt_rd=%b, need one-hot and strobes only with ack",
                         ack, rd_valid, rt_wr, rt_rd);
            end
            if (|ack) begin
                last_ack_cyc = cyc;
                checks++;
                if (exp_acc.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: ack=%b, none expected", ack);
                end else begin
                    me = exp_acc.pop_front();
                    exp_oh = N'(1) << me.id;
                    if (ack !== exp_oh || rt_wr !== !me.rd || rt_rd !== me.rd ||
                        rt_addr !== me.addr || rt_din !== me.din || busy !== 1'b1) begin
                        fails++;
                        $display("FAIL access: got ack=%b wr=%b rd=%b addr=%h din=%h busy=%b; want ack=%b wr=%b rd=%b addr=%h din=%h busy=1",
                                 ack, rt_wr, rt_rd, rt_addr, rt_din, busy,
                                 exp_oh, !me.rd, me.rd, me.addr, me.din);
                    end
                end
            end
            if (|rd_valid) begin
                last_rdv_cyc = cyc;
                last_rd_data = rd_data;
                checks++;
                if (exp_rd.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rd_valid: rd_valid=%b, none expected", rd_valid);
                end else begin
                    mr = exp_rd.pop_front();
                    exp_oh = N'(1) << mr.id;
                    if (rd_valid !== exp_oh || rd_data !== mr.data) begin
                        fails++;
                        $display("FAIL read_data: got rd_valid=%b rd_data=%h; want rd_valid=%b rd_data=%h",
                                 rd_valid, rd_data, exp_oh, mr.data);
                    end
                end
            end
        end
    end

    // Stimulus
    int issue_cyc;

    task automatic rand_stim();
        for (int i = 0; i < N; i++) begin
            sa[i] = 7'($urandom);
            sd[i] = 16'($urandom);
        end
        srd = 6'($urandom);
    endtask

    // Issue requests in mask; expect ngr grants. Each requester drops its req on
    // ack; with reraise it raises it again the following cycle.
    task automatic run_round(input logic [N-1:0] mask, input int ngr, input bit reraise);
        logic [N-1:0] set;
        logic [N-1:0] dropped;
        int granted;
        int budget;
        int w;
        @(negedge clk);
        set = mask;
        for (int g = 0; g < ngr; g++) begin
            w = pick(set, mptr);
            model_grant(w);
            if (!reraise) set[w] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = sa[i];
            req_din[i*DW +: DW]  = sd[i];
        end
        req_rd    = srd;
        issue_cyc = cyc;
        req       = mask;
        granted   = 0;
        dropped   = '0;
        budget    = 0;
        while (budget < 200) begin
            @(negedge clk);
            budget++;
            if (reraise && granted < ngr) req = req | dropped;
            dropped = '0;
            if (|ack) begin
                granted++;
                if (granted >= ngr) begin
                    req = '0;
                end else begin
                    req     = req & ~ack;
                    dropped = ack;
                end
            end
            if (req == '0 && !busy) break;
        end
        checks++;
        if (budget >= 200) begin
            fails++;
            $display("FAIL round_timeout: granted=%0d busy=%b, want %0d grants and idle", granted, busy, ngr);
            req = '0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
            fails++;
            $display("FAIL missing_output: pending acks=%0d reads=%0d, want 0 0", exp_acc.size(), exp_rd.size());
            exp_acc.delete();
            exp_rd.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    logic [N-1:0] m;

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack",    32'(ack), 0);
        chk("reset_rdv",    32'(rd_valid), 0);
        chk("reset_rddata", 32'(rd_data), 0);
        chk("reset_busy",   32'(busy), 0);
        chk("reset_rtaddr", 32'(rt_addr), 0);
        chk("reset_rtdin",  32'(rt_din), 0);
        chk("reset_strobe", 32'({rt_wr, rt_rd}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single write from requester 2
        rand_stim();
        sa[2] = 7'h05; sd[2] = 16'hA5A5; srd[2] = 1'b0;
        run_round(6'b000100, 1, 1'b0);
        chk("wr_ack_latency", 32'(last_ack_cyc), 32'(issue_cyc + 1));

        // Seed address 2 with 1234, then read it back through SPI
        sa[1] = 7'h02; sd[1] = 16'h1234; srd = '0;
        run_round(6'b000010, 1, 1'b0);
        sa[0] = 7'h02; srd = 6'b000001;
        run_round(6'b000001, 1, 1'b0);
        chk("rd_ack_latency", 32'(last_ack_cyc), 32'(issue_cyc + 1));
        chk("rd_valid_latency", 32'(last_rdv_cyc), 32'(issue_cyc + 3));
        chk("rd_data_1234", 32'(last_rd_data), 32'h1234);

        // Reset during a read ACCESS
        @(negedge clk);
        req_addr[0 +: AW] = 7'h02;
        req_rd = 6'b000001;
        req = 6'b000001;
        @(posedge clk);
        #1;
        chk("abort_in_access", 32'({ack, rt_rd}), 32'({6'b000001, 1'b1}));
        #1;
        rst = 1'b1;
        #1;
        chk("abort_strobes", 32'({ack, rd_valid, rt_rd, rt_wr}), 0);
        chk("abort_busy", 32'(busy), 0);
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 0);

        // Fairness: all requesting, re-raised after each ack
        rand_stim();
        srd = '0;
        run_round(6'b111111, 7, 1'b1);

        // Wrap: move pointer to 5, then 5 and 0 compete
        rand_stim();
        srd = '0;
        run_round(6'b010000, 1, 1'b0);
        run_round(6'b100001, 2, 1'b0);

        // Requester 3 drops its request before it wins
        rand_stim();
        run_round(6'b001010, 1, 1'b0);

        // Random traffic
        for (int r = 0; r < 40; r++) begin
            rand_stim();
            m = 6'($urandom_range(1, 63));
            run_round(m, $countones(m), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
